// File: rtl/rope_pkg.sv
// Shared types and constants for the rope (harpoon) controller.
//   rope_state_t : controller state encoding
//   GAME_PLAY    : game FSM mode code for "play"; must match the game FSM encoding
//   COORD_W      : screen coordinate width
package rope_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXTEND   = 2'd1,
    COOLDOWN = 2'd2
  } rope_state_t;

  localparam logic [1:0]  GAME_PLAY = 2'd1;
  localparam int unsigned COORD_W   = 11;

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for a level input (e.g. a key or fire request).
//   clk    : clock
//   resetN : synchronous reset, active high
//   in     : level input
//   pulse  : high for the cycle in which in is 1 and was 0 on the previous edge
// Holding the input high yields exactly one pulse.
module rise_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (resetN) prev_q <= 1'b0;
    else        prev_q <= in;
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/rope_controller.sv
// Rope (harpoon) shot sequencer: turns the fire request level into single shots,
// raises the rope tip once per frame, ends the shot on a ball hit or at the ceiling,
// then holds off further shots for a number of frames.
//   clk, resetN   : clock, synchronous active-high reset
//   startOfFrame  : one-cycle frame tick (motion tick)
//   gameState     : game mode code; GAME_PLAY enables the controller
//   ropeDeploy    : fire request level
//   playerX       : launch X, captured at fire
//   col_rope_ball : rope/ball collision (pulse or level)
//   ropeActive    : rope should be drawn
//   ropeX         : rope X latched at fire
//   ropeTopY      : current rope tip Y
//   ropeHitPulse  : one-cycle pulse on a ball hit
//   busy          : shot or cooldown in progress
// All outputs are registered.
module rope_controller
  import rope_pkg::*;
#(
  parameter int unsigned TOP_Y           = 32,
  parameter int unsigned FLOOR_Y         = 448,
  parameter int unsigned EXTEND_STEP     = 4,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [1:0]         gameState,
  input  logic               ropeDeploy,
  input  logic [COORD_W-1:0] playerX,
  input  logic               col_rope_ball,
  output logic               ropeActive,
  output logic [COORD_W-1:0] ropeX,
  output logic [COORD_W-1:0] ropeTopY,
  output logic               ropeHitPulse,
  output logic               busy
);

  localparam int unsigned CNT_W =
      (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [COORD_W-1:0] TopY    = COORD_W'(TOP_Y);
  localparam logic [COORD_W-1:0] FloorY  = COORD_W'(FLOOR_Y);
  localparam logic [COORD_W-1:0] Step    = COORD_W'(EXTEND_STEP);
  localparam logic [CNT_W-1:0]   CntInit = CNT_W'(COOLDOWN_FRAMES);

  rope_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] rope_x_d, rope_top_d;
  logic               active_d, busy_d, hit_d;
  logic               fire, play, can_step;
  logic [COORD_W-1:0] headroom;

  rise_edge_detect u_fire_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (ropeDeploy),
    .pulse  (fire)
  );

  assign play     = (gameState == GAME_PLAY);
  // The tip never sits above TOP_Y, so this subtraction cannot wrap.
  assign headroom = ropeTopY - TopY;
  assign can_step = (headroom > Step);

  // State and output registers
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ropeActive   <= 1'b0;
      busy         <= 1'b0;
      ropeHitPulse <= 1'b0;
      ropeX        <= '0;
      ropeTopY     <= FloorY;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ropeActive   <= active_d;
      busy         <= busy_d;
      ropeHitPulse <= hit_d;
      ropeX        <= rope_x_d;
      ropeTopY     <= rope_top_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (!play) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (fire) state_d = EXTEND;
        EXTEND: begin
          // Collision outranks the frame tick.
          if (col_rope_ball)                   state_d = COOLDOWN;
          else if (startOfFrame && !can_step)  state_d = COOLDOWN;
        end
        COOLDOWN: begin
          // A zero count only occurs with COOLDOWN_FRAMES = 0.
          if (cnt_q == '0)                                  state_d = IDLE;
          else if (startOfFrame && cnt_q == CNT_W'(1))      state_d = IDLE;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  // Registered-output next values
  always_comb begin
    rope_x_d   = ropeX;
    rope_top_d = ropeTopY;
    cnt_d      = cnt_q;
    hit_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (state_d == EXTEND) begin
          rope_x_d   = playerX;
          rope_top_d = FloorY;
        end
      end
      EXTEND: begin
        if (play) begin
          if (col_rope_ball) begin
            hit_d = 1'b1;
          end else if (startOfFrame) begin
            rope_top_d = can_step ? (ropeTopY - Step) : TopY;
          end
          if (state_d == COOLDOWN) cnt_d = CntInit;
        end
      end
      COOLDOWN: begin
        if (play && startOfFrame && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase

    // Any return to IDLE (shot done or leaving play) parks the tip on the floor.
    if (state_d == IDLE) begin
      rope_top_d = FloorY;
      cnt_d      = '0;
    end

    active_d = (state_d == EXTEND);
    busy_d   = (state_d != IDLE);
  end

endmodule

// File: tb/tb_rope_controller.sv
// Scoreboard bench for rope_controller: stimulus pushes hand-computed expected
// outputs after each checked edge; a monitor pops and compares on the falling edge.
module tb_rope_controller;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [1:0]  gameState = 2'd1;
  logic        ropeDeploy = 1'b0;
  logic [10:0] playerX = '0;
  logic        col_rope_ball = 1'b0;
  logic        ropeActive;
  logic [10:0] ropeX;
  logic [10:0] ropeTopY;
  logic        ropeHitPulse;
  logic        busy;

  always #5 clk = ~clk;

  rope_controller dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .gameState     (gameState),
    .ropeDeploy    (ropeDeploy),
    .playerX       (playerX),
    .col_rope_ball (col_rope_ball),
    .ropeActive    (ropeActive),
    .ropeX         (ropeX),
    .ropeTopY      (ropeTopY),
    .ropeHitPulse  (ropeHitPulse),
    .busy          (busy)
  );

  typedef struct {
    string       name;
    logic        act;
    logic [10:0] x;
    logic [10:0] top;
    logic        hit;
    logic        bsy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic a, input logic [10:0] x,
                            input logic [10:0] t, input logic h, input logic b);
    exp_t e;
    e.name = nm; e.act = a; e.x = x; e.top = t; e.hit = h; e.bsy = b;
    sb.push_back(e);
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      if ({ropeActive, ropeX, ropeTopY, ropeHitPulse, busy} !==
          {mon_e.act, mon_e.x, mon_e.top, mon_e.hit, mon_e.bsy}) begin
        n_bad++;
        $display("FAIL %s: got act=%0b x=%0d top=%0d hit=%0b busy=%0b, want act=%0b x=%0d top=%0d hit=%0b busy=%0b",
                 mon_e.name, ropeActive, ropeX, ropeTopY, ropeHitPulse, busy,
                 mon_e.act, mon_e.x, mon_e.top, mon_e.hit, mon_e.bsy);
      end
    end
  end

  initial begin
    // Reset
    tick();
    tick();
    expect_out("reset", 0, 0, 448, 0, 0);
    resetN = 1'b0;
    tick();

    // Fire at X=300, then keep the key held through the whole shot
    playerX = 300; ropeDeploy = 1'b1;
    tick();
    expect_out("fire", 1, 300, 448, 0, 1);
    playerX = 500;
    for (int k = 1; k <= 104; k++) begin
      frame();
      if (k < 104) expect_out("extend", 1, 300, 11'(448 - 4 * k), 0, 1);
      else         expect_out("ceiling", 0, 300, 32, 0, 1);
    end
    for (int k = 1; k <= 8; k++) begin
      frame();
      if (k < 8) expect_out("cooldown", 0, 300, 32, 0, 1);
      else       expect_out("cool_done", 0, 300, 448, 0, 0);
    end
    tick();
    expect_out("held_no_refire", 0, 300, 448, 0, 0);

    // Release and press again
    ropeDeploy = 1'b0;
    tick();
    ropeDeploy = 1'b1; playerX = 120;
    tick();
    expect_out("refire", 1, 120, 448, 0, 1);
    ropeDeploy = 1'b0;
    for (int k = 1; k <= 10; k++) frame();
    expect_out("ten_ticks", 1, 120, 408, 0, 1);

    // Level-held collision: one pulse only
    col_rope_ball = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) expect_out("hit", 0, 120, 408, 1, 1);
      else        expect_out("hit_held", 0, 120, 408, 0, 1);
    end
    col_rope_ball = 1'b0;
    for (int k = 1; k <= 8; k++) frame();
    expect_out("hit_cool_done", 0, 120, 448, 0, 0);

    // Collision and frame tick together at tip 36
    playerX = 200; ropeDeploy = 1'b1;
    tick();
    ropeDeploy = 1'b0;
    expect_out("fire3", 1, 200, 448, 0, 1);
    for (int k = 1; k <= 103; k++) frame();
    expect_out("at36", 1, 200, 36, 0, 1);
    startOfFrame = 1'b1; col_rope_ball = 1'b1;
    tick();
    expect_out("hit_vs_frame", 0, 200, 36, 1, 1);
    startOfFrame = 1'b0; col_rope_ball = 1'b0;
    tick();
    expect_out("pulse_end", 0, 200, 36, 0, 1);
    for (int k = 1; k <= 8; k++) frame();
    expect_out("cool3_done", 0, 200, 448, 0, 0);

    // Leaving play mid-EXTEND
    playerX = 50; ropeDeploy = 1'b1;
    tick();
    ropeDeploy = 1'b0;
    expect_out("fire4", 1, 50, 448, 0, 1);
    for (int k = 1; k <= 5; k++) frame();
    expect_out("five_ticks", 1, 50, 428, 0, 1);
    gameState = 2'd2; col_rope_ball = 1'b1;
    tick();
    expect_out("leave_play", 0, 50, 448, 0, 0);
    gameState = 2'd1;
    tick();
    expect_out("col_idle", 0, 50, 448, 0, 0);
    col_rope_ball = 1'b0;

    // Fire outside play is ignored
    gameState = 2'd0; ropeDeploy = 1'b1;
    tick();
    expect_out("fire_not_play", 0, 50, 448, 0, 0);
    gameState = 2'd1; ropeDeploy = 1'b0;
    tick();

    // Reset mid-COOLDOWN
    playerX = 70; ropeDeploy = 1'b1;
    tick();
    ropeDeploy = 1'b0;
    expect_out("fire5", 1, 70, 448, 0, 1);
    col_rope_ball = 1'b1;
    tick();
    expect_out("hit_at_floor", 0, 70, 448, 1, 1);
    col_rope_ball = 1'b0;
    frame();
    expect_out("cool_mid", 0, 70, 448, 0, 1);
    resetN = 1'b1; col_rope_ball = 1'b1;
    tick();
    expect_out("reset_mid_cool", 0, 0, 448, 0, 0);
    resetN = 1'b0;
    tick();
    expect_out("col_after_reset", 0, 0, 448, 0, 0);
    col_rope_ball = 1'b0;

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rope_controller.md
# rope_controller

Sequences the player's rope (harpoon) resource during play. It turns the game FSM's `ropeDeploy` level into single shots, and grows the rope tip upward once per frame. It ends a shot on a ball hit or on reaching the ceiling, then enforces a cooldown before the next shot. It sits between the game state machine, the collision detector and the rope drawing object.

## Interface
Parameters:
- `TOP_Y`, default 32: ceiling Y; the rope tip never goes above it.
- `FLOOR_Y`, default 448: rope base Y and tip Y when idle. Must be greater than `TOP_Y`.
- `EXTEND_STEP`, default 4: pixels the tip rises per frame tick. Must be at least 1.
- `COOLDOWN_FRAMES`, default 8: frame ticks spent in COOLDOWN after a shot ends.

Ports:
- `clk`, in, 1: single clock.
- `resetN`, in, 1: synchronous, active-high reset; asserted when 1.
- `startOfFrame`, in, 1: one-cycle pulse per video frame; the motion tick.
- `gameState`, in, 2: game mode code. 1 means play.
- `ropeDeploy`, in, 1: fire request level from the game FSM.
- `playerX`, in, 11: player's rope-launch X.
- `col_rope_ball`, in, 1: rope/ball collision. May be a pulse or a level.
- `ropeActive`, out, 1: rope is to be drawn.
- `ropeX`, out, 11: rope X, latched at fire.
- `ropeTopY`, out, 11: current tip Y.
- `ropeHitPulse`, out, 1: one-cycle pulse on a ball hit; drives ball split and score.
- `busy`, out, 1: a shot or cooldown is in progress.

## Operation
- States: IDLE, EXTEND, COOLDOWN.
- All outputs are registered.

Fire detection:
- `prevDeploy` is registered every cycle.
- A fire event is `ropeDeploy & ~prevDeploy`.
- Holding the key fires once. Fire events outside IDLE are dropped, not queued.

IDLE:
- `ropeActive`=0, `busy`=0, `ropeTopY`=`FLOOR_Y`.
- On a fire event with `gameState`==1:
  - `ropeX` <= `playerX`
  - `ropeTopY` <= `FLOOR_Y`
  - `ropeActive` <= 1
  - go to EXTEND.

EXTEND (`ropeActive`=1, `busy`=1):
- Priority 1, `col_rope_ball`=1:
  - `ropeHitPulse` <= 1 for one cycle
  - `ropeActive` <= 0
  - `ropeTopY` is held
  - go to COOLDOWN. This wins over a simultaneous `startOfFrame`.
- Priority 2, `startOfFrame`:
  - If `ropeTopY - TOP_Y` > `EXTEND_STEP`, then `ropeTopY` -= `EXTEND_STEP`.
  - Otherwise `ropeTopY` <= `TOP_Y`, `ropeActive` <= 0, go to COOLDOWN, with no hit pulse.
  - Compute the difference first so there is no unsigned underflow.
- `ropeX` is frozen while the player moves.

COOLDOWN (`busy`=1, `ropeActive`=0):
- Entry loads the counter with `COOLDOWN_FRAMES`.
- Each `startOfFrame` decrements the counter.
- Go to IDLE on the tick that decrements it from 1 to 0.
- If `COOLDOWN_FRAMES`=0, go to IDLE on the cycle after entry.
- On IDLE entry, `ropeTopY` <= `FLOOR_Y`.

Leaving play:
- `gameState`!=1 in any state forces IDLE on the next edge.
- Counters clear, `ropeTopY` <= `FLOOR_Y`, and no hit pulse is generated.

Collisions:
- `col_rope_ball` is ignored outside EXTEND.

## Timing
Reset (`resetN`=1 at an edge) gives:
- State IDLE
- `ropeActive`=0, `busy`=0, `ropeHitPulse`=0
- `ropeX`=0, `ropeTopY`=`FLOOR_Y`
- `prevDeploy`=0, cooldown counter=0

Reset applied mid-shot aborts it with no pulse.

Latency:
- Fire sampled at edge N: `ropeActive`=1 after edge N.
- Collision sampled at edge M: `ropeHitPulse`=1 for exactly cycle M to M+1, and `ropeActive`=0 after edge M.
- A level-held `col_rope_ball` produces one pulse only, because the state has already left EXTEND.
- Extend duration is ceil((`FLOOR_Y`-`TOP_Y`)/`EXTEND_STEP`) frame ticks. With defaults that is 104.

## Structure
- Package `rope_pkg` holds:
  - `rope_state_t` enum {IDLE, EXTEND, COOLDOWN}
  - `GAME_PLAY` = 2'd1 (shared with the game FSM encoding)
  - `COORD_W` = 11
- Sub-module `rise_edge_detect` (clk, resetN, in, pulse) produces the fire event. It is reusable for other key inputs.

## Test plan
- Reset, then a fire event with `gameState`=1 and `playerX`=300 → `ropeActive`=1, `ropeX`=300, `ropeTopY`=448 next cycle, `busy`=1.
- No collision, 104 `startOfFrame` ticks → `ropeTopY` goes 444, 440, …, 32. The last tick gives `ropeActive`=0 and COOLDOWN. After 8 more ticks `busy`=0 and `ropeTopY`=448.
- `col_rope_ball` held high for 5 cycles after 10 ticks (`ropeTopY`=408) → a single one-cycle `ropeHitPulse`, and `ropeActive`=0.
- `col_rope_ball` and `startOfFrame` in the same cycle at `ropeTopY`=36 → hit pulse asserted, `ropeTopY` stays 36.
- `ropeDeploy` held through a full shot and cooldown → no second shot. Release, then press again → new shot fires.
- `gameState`→2 mid-EXTEND, and separately `resetN`=1 mid-COOLDOWN → IDLE next edge, `ropeTopY`=448, no `ropeHitPulse`, and `col_rope_ball` is then ignored.
